// File: rtl/morse_letter_decoder.sv
// Morse key to letter-index decoder: times presses and gaps against a prescaled tick,
// then emits a 5-bit A..Z index (31 = invalid). Optional debounce: define MORSE_DEBOUNCE_EN.
module morse_letter_decoder #(
    parameter int TICK_DIV       = 500000,
    parameter int CNT_W          = 8,
    parameter int DOT_MAX        = 40,
    parameter int GAP_TICKS      = 60,
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic       ClkPort,
    input  logic       reset_n,
    input  logic       key,
    output logic [4:0] LETTER,
    output logic       letter_valid,
    output logic [2:0] sym_count,
    output logic       key_active
);
    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_TICKS);

    if (TICK_DIV < 2)       begin : g_bad_div $error("TICK_DIV must be >= 2"); end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_db  $error("DEBOUNCE_TICKS must be >= 1"); end

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]       sym_q, sym_d;
    logic [2:0]       sym_cnt_q, sym_cnt_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       letter_q, letter_d;
    logic             letter_vld_q, letter_vld_d;
    logic             key_meta_q, key_sync_q;
    logic             tick, kq;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

`ifdef MORSE_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            kq_q, kq_d;

    // A new level must be seen on DEBOUNCE_TICKS consecutive ticks; any bounce back restarts.
    always_comb begin
        db_cnt_d = db_cnt_q;
        kq_d     = kq_q;
        if (key_sync_q == kq_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q == DB_LAST) begin
                kq_d     = key_sync_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_q <= '0;
            kq_q     <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            kq_q     <= kq_d;
        end
    end
    assign kq = kq_q;
`else
    assign kq = key_sync_q;
`endif

    // Index is {count, symbols}; unused high symbol bits are always zero.
    function automatic logic [4:0] decode(input logic [2:0] n, input logic [3:0] s);
        case ({n, s})
            7'b001_0000: decode = 5'd4;  // E
            7'b001_0001: decode = 5'd19; // T
            7'b010_0000: decode = 5'd8;  // I
            7'b010_0001: decode = 5'd0;  // A
            7'b010_0010: decode = 5'd13; // N
            7'b010_0011: decode = 5'd12; // M
            7'b011_0000: decode = 5'd18; // S
            7'b011_0001: decode = 5'd20; // U
            7'b011_0010: decode = 5'd17; // R
            7'b011_0011: decode = 5'd22; // W
            7'b011_0100: decode = 5'd3;  // D
            7'b011_0101: decode = 5'd10; // K
            7'b011_0110: decode = 5'd6;  // G
            7'b011_0111: decode = 5'd14; // O
            7'b100_0000: decode = 5'd7;  // H
            7'b100_0001: decode = 5'd21; // V
            7'b100_0010: decode = 5'd5;  // F
            7'b100_0100: decode = 5'd11; // L
            7'b100_0110: decode = 5'd15; // P
            7'b100_0111: decode = 5'd9;  // J
            7'b100_1000: decode = 5'd1;  // B
            7'b100_1001: decode = 5'd23; // X
            7'b100_1010: decode = 5'd2;  // C
            7'b100_1011: decode = 5'd24; // Y
            7'b100_1100: decode = 5'd25; // Z
            7'b100_1101: decode = 5'd16; // Q
            default:     decode = 5'd31;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        press_cnt_d  = press_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sym_d        = sym_q;
        sym_cnt_d    = sym_cnt_q;
        ovf_d        = ovf_q;
        letter_d     = letter_q;
        letter_vld_d = 1'b0;
        case (state_q)
            IDLE: if (kq) begin
                press_cnt_d = '0;
                state_d     = PRESS;
            end
            PRESS: begin
                // Release is checked first so it sees the count before a coincident tick.
                if (!kq) begin
                    if (press_cnt_q != '0) begin
                        if (sym_cnt_q < 3'd4) begin
                            sym_d     = {sym_q[2:0], press_cnt_q > DOT_LIM};
                            sym_cnt_d = sym_cnt_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (tick && press_cnt_q != CNT_MAX) begin
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (kq) begin
                    press_cnt_d = '0;
                    state_d     = PRESS;
                end else if (tick) begin
                    if (gap_cnt_q != CNT_MAX) gap_cnt_d = gap_cnt_q + 1'b1;
                    if (gap_cnt_d == GAP_LIM) begin
                        state_d = EMIT;
                        if (sym_cnt_q != 3'd0) begin
                            letter_d     = ovf_q ? 5'd31 : decode(sym_cnt_q, sym_q);
                            letter_vld_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                sym_d     = '0;
                sym_cnt_d = '0;
                ovf_d     = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            press_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            sym_q        <= '0;
            sym_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            letter_q     <= 5'd31;
            letter_vld_q <= 1'b0;
            key_meta_q   <= 1'b0;
            key_sync_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            press_cnt_q  <= press_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            sym_q        <= sym_d;
            sym_cnt_q    <= sym_cnt_d;
            ovf_q        <= ovf_d;
            letter_q     <= letter_d;
            letter_vld_q <= letter_vld_d;
            key_meta_q   <= key;
            key_sync_q   <= key_meta_q;
        end
    end

    assign LETTER       = letter_q;
    assign letter_valid = letter_vld_q;
    assign sym_count    = sym_cnt_q;
    assign key_active   = kq;
endmodule

// File: doc/morse_letter_decoder.md
# morse_letter_decoder

Converts a single Morse key input into 5-bit letter codes for the VGA letter renderer. The block times key presses and releases against a divided-clock tick and classifies each press as a dot or a dash. After a letter gap it decodes the collected symbols into a letter index, drives `LETTER`, and pulses `letter_valid`. It sits between the button/switch inputs and the display logic, in the same `ClkPort` domain.

## Interface
- `TICK_DIV`, default 500000: `ClkPort` cycles per timing tick (5 ms at 100 MHz); must be ≥2.
- `CNT_W`, default 8: width of the press and gap tick counters, which saturate.
- `DOT_MAX`, default 40: a press of 1..`DOT_MAX` ticks is a dot; more than `DOT_MAX` ticks is a dash.
- `GAP_TICKS`, default 60: release time in ticks that ends a letter.
- `DEBOUNCE_TICKS`, default 2: key stability requirement, used only under `MORSE_DEBOUNCE_EN`.

Ports:
- `ClkPort` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `key` in 1: raw Morse key, 1 = pressed, asynchronous to `ClkPort`.
- `LETTER` out 5: 0..25 = A..Z; 31 = blank/invalid; 26..30 are never driven.
- `letter_valid` out 1: one-cycle pulse when `LETTER` is updated.
- `sym_count` out 3: symbols collected for the current letter, 0..4.
- `key_active` out 1: the qualified key level.

## Operation
- `key` passes through a 2-flop synchronizer (and the optional debounce) to give `kq`.
- A free-running prescaler produces `tick`, a one-cycle pulse every `TICK_DIV` cycles. The prescaler is not reset by FSM activity.
- The symbol shift register `sym[3:0]` shifts left and inserts each new symbol at bit 0 (dot = 0, dash = 1). Example: A (.-) is `sym_count` = 2, `sym[1:0]` = 01.
- FSM states:
  - `IDLE`: on `kq` rising, clear `press_cnt` and go to `PRESS`.
  - `PRESS`: on each `tick`, increment `press_cnt` (saturating at 2^`CNT_W`−1). On `kq` falling:
    - If `press_cnt` = 0 (glitch), record no symbol.
    - Otherwise, if `sym_count` < 4, shift in the symbol and increment `sym_count`.
    - Otherwise set the sticky `ovf` flag.
    - Then clear `gap_cnt` and go to `GAP`.
  - `GAP`: on each `tick`, increment `gap_cnt`. On `kq` rising, clear `press_cnt` and return to `PRESS`. When `gap_cnt` reaches `GAP_TICKS`, go to `EMIT`.
  - `EMIT` (one cycle):
    - If `sym_count` = 0, update nothing and pulse nothing.
    - Otherwise decode with the standard international Morse table for A–Z into `LETTER`. If `ovf` is set or the code is not a letter (for example ..--, .-.-, ---., ----), drive `LETTER` = 31.
    - Pulse `letter_valid` (only when `sym_count` ≠ 0), clear `sym`, `sym_count` and `ovf`, and go to `IDLE`.
- `LETTER` holds its value between emits.
- If `kq` rises during the `EMIT` cycle, the FSM enters `PRESS` on the next cycle, provided `kq` is still high in `IDLE`.

## Timing
- Reset values: `LETTER` = 31, `letter_valid` = 0, `sym_count` = 0, `key_active` = 0. The FSM, counters, `ovf` and the prescaler are all reset to 0 / `IDLE`.
- Assertion of `reset_n` mid-letter discards all partial state immediately; no `letter_valid` pulse is produced.
- `key` to `kq` latency is 2 cycles without debounce.
- `letter_valid` and the new `LETTER` value appear together, registered, 1 cycle after the `tick` on which `gap_cnt` reaches `GAP_TICKS`.
- A simultaneous `tick` and `kq` edge resolves as follows:
  - In `PRESS`, a falling edge samples `press_cnt` *before* that tick's increment.
  - In `GAP`, a rising edge wins over the terminal gap count.
- Comparisons use unsigned `CNT_W`-bit values. Parameters must satisfy `DOT_MAX` < 2^`CNT_W`−1 and `GAP_TICKS` ≤ 2^`CNT_W`−1.

## Configuration
- `MORSE_DEBOUNCE_EN`:
  - Defined: the synchronized key must hold a new level for `DEBOUNCE_TICKS` consecutive ticks before `kq` changes. This adds up to (`DEBOUNCE_TICKS`+1)·`TICK_DIV` cycles of latency to each edge.
  - Undefined: `kq` is the synchronizer output and `DEBOUNCE_TICKS` is ignored.

## Test plan
All scenarios use `TICK_DIV`=4, `DOT_MAX`=3, `GAP_TICKS`=5, `CNT_W`=8, and no debounce.
- Reset: hold `reset_n`=0, toggle `key` → `LETTER`=31, `letter_valid`=0, `sym_count`=0 throughout. Release reset → outputs unchanged.
- Single dot (press 8 clk), then release 30 clk → one `letter_valid` pulse with `LETTER`=4 (E). Dash (press 24 clk) → `LETTER`=19 (T).
- Sequence dot, dash, dot, dot (gaps of 8 clk) → `sym_count` steps 1,2,3,4, then `LETTER`=11 (L) with exactly one pulse.
- Five symbols, or ..--, → `LETTER`=31 with a pulse. An immediately following dash-dash letter → `LETTER`=12 (M).
- A 1-clk glitch press aligned away from a tick → no symbol and no pulse; `LETTER` retains its previous value.
- `reset_n` pulsed low during `GAP` with `sym_count`=2 → no pulse, `sym_count`=0. The next dot letter decodes correctly as E.
